// File: rtl/ascon_feeder_pkg.sv
// Shared definitions for the Ascon byte feeder and the cipher core:
// frame type codes, text data_type encodings, word width and FSM states.
package ascon_feeder_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        FT_KEY    = 3'd0,
        FT_NONCE  = 3'd1,
        FT_ASSOC  = 3'd2,
        FT_PLAIN  = 3'd3,
        FT_CIPHER = 3'd4
    } frame_type_e;

    typedef enum logic [1:0] {
        DT_EMPTY  = 2'd0,
        DT_PLAIN  = 2'd1,
        DT_CIPHER = 2'd2
    } data_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_PRESENT,
        ST_DROP
    } feeder_state_e;

    // Header type field names one of the five known frame kinds
    function automatic logic hdr_type_ok(input logic [2:0] t);
        return t <= 3'd4;
    endfunction

    // Key and nonce frames must carry exactly four words
    function automatic logic hdr_len_ok(input logic [2:0] t, input logic [3:0] n);
        return !(((t == FT_KEY) || (t == FT_NONCE)) && (n != 4'd3));
    endfunction

endpackage

// File: rtl/ascon_feeder_if.sv
// Byte input stream plus the four word channels towards the cipher core.
interface ascon_feeder_if;
    import ascon_feeder_pkg::*;

    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;

    logic [WORD_W-1:0] key_word;
    logic              key_valid;
    logic              key_ready;

    logic [WORD_W-1:0] nonce_word;
    logic              nonce_valid;
    logic              nonce_ready;

    logic [WORD_W-1:0] assoc_word;
    logic              assoc_valid;
    logic              assoc_ready;

    logic [WORD_W-1:0] data_word;
    logic [1:0]        data_type;
    logic              data_valid;
    logic              data_last;
    logic              data_ready;

    logic              err;

    modport master (
        input  in_byte, in_valid, key_ready, nonce_ready, assoc_ready, data_ready,
        output in_ready, key_word, key_valid, nonce_word, nonce_valid,
               assoc_word, assoc_valid, data_word, data_type, data_valid,
               data_last, err
    );

    modport slave (
        output in_byte, in_valid, key_ready, nonce_ready, assoc_ready, data_ready,
        input  in_ready, key_word, key_valid, nonce_word, nonce_valid,
               assoc_word, assoc_valid, data_word, data_type, data_valid,
               data_last, err
    );

endinterface

// File: rtl/ascon_byte_packer.sv
// Packs bytes big-endian into a 32-bit word; strobes when the fourth byte
// of a word is being accepted.
module ascon_byte_packer
    import ascon_feeder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);

    logic [1:0] byte_cnt;

    assign word_done = byte_en && (byte_cnt == 2'd3);

    // Byte counter and shift register; earliest byte ends up in [31:24]
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (byte_en) begin
            byte_cnt <= byte_cnt + 2'd1;
            word     <= {word[WORD_W-9:0], byte_in};
        end
    end

endmodule

// File: rtl/ascon_feeder.sv
// Parses header-framed byte stream and routes packed words to the key,
// nonce, associated-data or text channel of the Ascon core.
module ascon_feeder
    import ascon_feeder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic   clk,
    input  logic   rst,
    ascon_feeder_if.master bus
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    feeder_state_e     state, state_nx;
    logic [2:0]        hdr_type;
    logic              hdr_last;
    logic [3:0]        hdr_n;
    logic [3:0]        word_cnt;
    logic [TO_W-1:0]   to_cnt, to_nx;
    logic              err_q, err_set;
    logic              hdr_load, word_inc;
    logic              in_frame, timeout, sel_ready, present, final_word;
    logic [WORD_W-1:0] pk_word;
    logic              pk_done;

    assign in_frame   = (state == ST_COLLECT) || (state == ST_DROP);
    assign timeout    = in_frame && !bus.in_valid && (to_cnt == TO_LAST);
    assign present    = (state == ST_PRESENT);
    assign final_word = (word_cnt == hdr_n);

    ascon_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     ((state == ST_IDLE) || timeout),
        .byte_en   (in_frame && bus.in_valid),
        .byte_in   (bus.in_byte),
        .word      (pk_word),
        .word_done (pk_done)
    );

    // Ready of whichever channel the current frame targets
    always_comb begin
        sel_ready = 1'b0;
        case (hdr_type)
            FT_KEY:             sel_ready = bus.key_ready;
            FT_NONCE:           sel_ready = bus.nonce_ready;
            FT_ASSOC:           sel_ready = bus.assoc_ready;
            FT_PLAIN, FT_CIPHER: sel_ready = bus.data_ready;
            default:            sel_ready = 1'b0;
        endcase
    end

    // Next-state, header latch, word-advance and error decisions
    always_comb begin
        state_nx = state;
        err_set  = 1'b0;
        hdr_load = 1'b0;
        word_inc = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (!hdr_type_ok(bus.in_byte[7:5])) begin
                        err_set = 1'b1;
                    end else if (!hdr_len_ok(bus.in_byte[7:5], bus.in_byte[3:0])) begin
                        err_set  = 1'b1;
                        hdr_load = 1'b1;
                        state_nx = ST_DROP;
                    end else begin
                        hdr_load = 1'b1;
                        state_nx = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                if (pk_done) begin
                    state_nx = ST_PRESENT;
                end else if (timeout) begin
                    err_set  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (sel_ready) begin
                    if (final_word) begin
                        state_nx = ST_IDLE;
                    end else begin
                        word_inc = 1'b1;
                        state_nx = ST_COLLECT;
                    end
                end
            end
            ST_DROP: begin
                if (pk_done) begin
                    if (final_word) state_nx = ST_IDLE;
                    else            word_inc = 1'b1;
                end else if (timeout) begin
                    err_set  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Input-idle counter only runs while a frame is being received
    always_comb begin
        to_nx = '0;
        if (in_frame && !bus.in_valid && !timeout) to_nx = to_cnt + TO_W'(1);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    // Header fields, word counter, idle counter and error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_type <= '0;
            hdr_last <= 1'b0;
            hdr_n    <= '0;
            word_cnt <= '0;
            to_cnt   <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q  <= err_set;
            to_cnt <= to_nx;
            if (hdr_load) begin
                hdr_type <= bus.in_byte[7:5];
                hdr_last <= bus.in_byte[4];
                hdr_n    <= bus.in_byte[3:0];
                word_cnt <= '0;
            end else if (word_inc) begin
                word_cnt <= word_cnt + 4'd1;
            end
        end
    end

    // Channel outputs: only the targeted channel shows the word while presenting
    always_comb begin
        bus.in_ready    = rst && !present;
        bus.key_valid   = present && (hdr_type == FT_KEY);
        bus.nonce_valid = present && (hdr_type == FT_NONCE);
        bus.assoc_valid = present && (hdr_type == FT_ASSOC);
        bus.data_valid  = present && ((hdr_type == FT_PLAIN) || (hdr_type == FT_CIPHER));
        bus.key_word    = bus.key_valid   ? pk_word : '0;
        bus.nonce_word  = bus.nonce_valid ? pk_word : '0;
        bus.assoc_word  = bus.assoc_valid ? pk_word : '0;
        bus.data_word   = bus.data_valid  ? pk_word : '0;
        bus.data_type   = DT_EMPTY;
        if (bus.data_valid) bus.data_type = (hdr_type == FT_PLAIN) ? DT_PLAIN : DT_CIPHER;
        bus.data_last   = bus.data_valid && hdr_last && final_word;
        bus.err         = err_q;
    end

endmodule

// File: doc/ascon_feeder.md
ASCON_FEEDER -- requirements
Module: ascon_feeder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: idle-input cycles tolerated mid-frame before abort.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 in_byte  input  8  GPIO byte stream; in_valid input 1; in_ready output 1; a byte transfers when in_valid & in_ready.
REQ-005 key_word output 32, key_valid output 1, key_ready input 1: key channel to the cipher core.
REQ-006 nonce_word output 32, nonce_valid output 1, nonce_ready input 1: nonce channel.
REQ-007 assoc_word output 32, assoc_valid output 1, assoc_ready input 1: associated-data channel.
REQ-008 data_word output 32, data_type output 2 (1 plain, 2 cipher), data_valid output 1, data_last output 1, data_ready input 1: text channel.
REQ-009 err output 1: one-cycle pulse on a malformed or aborted frame.

Function
REQ-010 Frame = header byte then 4*(N+1) payload bytes; header [7:5] type (0 key, 1 nonce, 2 assoc, 3 plain, 4 cipher), [4] last flag, [3:0] N (word count minus 1, 1..16 words).
REQ-011 Payload is big-endian: first byte of a word to [31:24], fourth to [7:0].
REQ-012 States: IDLE (await header), COLLECT (pack bytes), PRESENT (word valid, await ready), DROP (discard payload).
REQ-013 IDLE: in_ready=1; valid header -> COLLECT, latch type/last/N, byte and word counters to 0.
REQ-014 Header type 5..7 -> err pulse next cycle, stay IDLE; next byte is treated as a header.
REQ-015 Key or nonce header with N != 3 -> err pulse, enter DROP, consume exactly 4*(N+1) bytes, return to IDLE.
REQ-016 COLLECT: in_ready=1; fourth byte accepted in cycle n -> selected channel valid=1 with full word in cycle n+1 (state PRESENT).
REQ-017 PRESENT: in_ready=0; word and valid held stable until channel ready=1; exactly one channel valid at any time.
REQ-018 On handshake: if more words remain -> COLLECT, word counter +1; else -> IDLE.
REQ-019 data_last=1 only with the final word of a plain/cipher frame whose header last flag=1; 0 otherwise.
REQ-020 Header last flag on key/nonce/assoc frames is ignored without error.
REQ-021 Timeout counter clears on every accepted byte and on entry to COLLECT/DROP; counts cycles in COLLECT or DROP without in_valid; reaching TIMEOUT_CYCLES -> err pulse, partial word discarded, IDLE.
REQ-022 Timeout counter does not run in IDLE or PRESENT (downstream stall is never an error).
REQ-023 Counters: byte 2 bits wrapping 3->0 at word completion; word 4 bits compared to latched N; no wrap past N.
REQ-024 Minimum throughput one word per 5 cycles (4 byte cycles + 1 presentation cycle with ready held high).

Reset
REQ-025 While rst=0: state IDLE, all *_valid=0, data_last=0, err=0, in_ready=0, all word outputs=0, data_type=0, all counters=0.
REQ-026 Reset asserted mid-frame or mid-PRESENT discards the frame immediately (asynchronous); no partial word is emitted after release.
REQ-027 First cycle after release in_ready=1 and the next byte is a header.

Structure
REQ-028 Shared package holds type codes (key, nonce, assoc, plain, cipher), data_type encodings (empty 0, plain 1, cipher 2) and the 32-bit word width, used by this block and the cipher core.
REQ-029 One sub-module, ascon_byte_packer (byte counter + 32-bit shift register with word-complete strobe), is natural; FSM and routing stay in ascon_feeder.

Verification
REQ-030 Header 0x03, bytes 00..0F, key_ready=1 -> key_word 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F in order, no err.
REQ-031 Header 0x71 (plain, last, 2 words), bytes AA..B1, data_ready held 0 for 10 cycles -> data_word 0xAAABACAD held stable with data_type=1, then 0xAEAFB0B1 with data_last=1.
REQ-032 Header 0x21 (nonce, N=1) + 8 bytes, then header 0x40 + 4 bytes -> one err pulse, no nonce_valid, then one assoc word delivered.
REQ-033 Header 0xE0 -> err pulse; following header 0x80 + 4 bytes -> one cipher word, data_type=2, data_last=0.
REQ-034 TIMEOUT_CYCLES=16, header 0x40 + 2 bytes, in_valid low 16 cycles -> err pulse, no assoc_valid, IDLE accepts next header.
REQ-035 rst=0 asserted while key_valid=1 -> key_valid=0 same cycle (async); after release, a fresh key frame delivers 4 correct words.
